// File: rtl/b06_cmp_cnt.sv
`default_nettype none
// ============================================================================
// Module   : b06_cmp_cnt
// Purpose  : Datapath/counter peer of the b06 interrupt handler. Produces the
//            registered operand-match flag (eql) and the counter-terminal flag
//            (cont_eql), and captures the handler's uscite code on each rising
//            edge of ackout.
// Options  : B06_CNT_SAT_EN - when defined, the counter saturates at TERM-1
//            (cont_eql held high) instead of wrapping to 0 with a one-cycle
//            cont_eql pulse.
// Revision : 1.0 - initial release
// ============================================================================
module b06_cmp_cnt #(
   parameter int DW   = 8,
   parameter int CW   = 4,
   parameter int TERM = 10
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [1:0]    cc_mux,
   input  logic [1:0]    uscite,
   input  logic          enable_count,
   input  logic          ackout,
   input  logic [DW-1:0] data_in,
   input  logic [DW-1:0] ref_in,
   input  logic          ref_load,
   output logic          eql,
   output logic          cont_eql,
   output logic [CW-1:0] count,
   output logic [1:0]    code_out,
   output logic          code_valid,
   output logic          active
);

   localparam logic [CW-1:0] TERM_M1 = CW'(TERM - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      CNT  = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [DW-1:0] ref_reg;
   logic [DW-1:0] sample_reg;
   logic          ack_d;

   logic [DW-1:0] sel;
   logic          cmp_hit;
   logic          at_term;
   logic [CW-1:0] inc_count;
   logic          inc_cont;
   logic [CW-1:0] drop_count;

   logic          eql_nxt;
   logic          cont_nxt;
   logic [CW-1:0] count_nxt;
   logic          ref_we;
   logic          ack_rise;

   // Operand select and full-width compare against the stored reference.
   always_comb begin
      sel = data_in;
      case (cc_mux)
         2'b01:   sel = data_in;
         2'b10:   sel = ~data_in;
         2'b11:   sel = sample_reg;
         default: sel = data_in;
      endcase
      cmp_hit = (sel == ref_reg);
   end

   // Counter step: the value and terminal flag produced by one enabled cycle,
   // plus what the count becomes when enable_count drops in CNT.
   always_comb begin
      at_term = (count == TERM_M1);
`ifdef B06_CNT_SAT_EN
      inc_count  = at_term ? TERM_M1 : (count + CNT_ONE);
      inc_cont   = (inc_count == TERM_M1);
      drop_count = at_term ? '0 : count;
`else
      inc_count  = at_term ? '0 : (count + CNT_ONE);
      inc_cont   = at_term;
      drop_count = count;
`endif
   end

   // Next-state and next-output decode for the IDLE/CMP/CNT machine.
   always_comb begin
      state_nxt = state;
      eql_nxt   = eql;
      cont_nxt  = 1'b0;
      count_nxt = count;
      ref_we    = 1'b0;

      case (state)
         IDLE: begin
            // enable_count is ignored here: a load only arms the compare.
            eql_nxt = 1'b0;
            if (ref_load) begin
               ref_we    = 1'b1;
               state_nxt = CMP;
            end
         end

         CMP: begin
            if (cc_mux != 2'b00) begin
               eql_nxt = cmp_hit;
            end
            ref_we = ref_load;
            if (enable_count) begin
               state_nxt = CNT;
               count_nxt = inc_count;
               cont_nxt  = inc_cont;
            end
         end

         CNT: begin
            if (cc_mux != 2'b00) begin
               eql_nxt = cmp_hit;
            end
            ref_we = ref_load;
            if (enable_count) begin
               count_nxt = inc_count;
               cont_nxt  = inc_cont;
            end else begin
               state_nxt = CMP;
               count_nxt = drop_count;
            end
         end

         default: begin
            state_nxt = IDLE;
            eql_nxt   = 1'b0;
         end
      endcase
   end

   // A strobe-worthy acknowledge edge; suppressed while the block is idle.
   always_comb begin
      ack_rise = ackout && !ack_d && (state != IDLE);
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Compare/count outputs and the active flag, all registered.
   always_ff @(posedge clock) begin
      if (!reset) begin
         eql      <= 1'b0;
         cont_eql <= 1'b0;
         count    <= '0;
         active   <= 1'b0;
      end else begin
         eql      <= eql_nxt;
         cont_eql <= cont_nxt;
         count    <= count_nxt;
         active   <= (state_nxt != IDLE);
      end
   end

   // Reference register; a reload takes effect after this cycle's compare.
   always_ff @(posedge clock) begin
      if (!reset) begin
         ref_reg <= '0;
      end else if (ref_we) begin
         ref_reg <= ref_in;
      end
   end

   // One-cycle delayed copy of data_in used by the cc_mux==11 source.
   always_ff @(posedge clock) begin
      if (!reset) begin
         sample_reg <= '0;
      end else begin
         sample_reg <= data_in;
      end
   end

   // ackout history tracks in every state so an edge seen in IDLE is consumed.
   always_ff @(posedge clock) begin
      if (!reset) begin
         ack_d <= 1'b0;
      end else begin
         ack_d <= ackout;
      end
   end

   // Capture uscite on a qualified ackout rising edge with a one-cycle strobe.
   always_ff @(posedge clock) begin
      if (!reset) begin
         code_out   <= 2'b00;
         code_valid <= 1'b0;
      end else begin
         code_valid <= ack_rise;
         if (ack_rise) begin
            code_out <= uscite;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_b06_cmp_cnt.sv
`default_nettype none
// ============================================================================
// Module   : tb_b06_cmp_cnt
// Purpose  : Directed self-checking bench for b06_cmp_cnt (TERM=10, CW=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_b06_cmp_cnt;

   logic       clock;
   logic       reset;
   logic [1:0] cc_mux;
   logic [1:0] uscite;
   logic       enable_count;
   logic       ackout;
   logic [7:0] data_in;
   logic [7:0] ref_in;
   logic       ref_load;
   logic       eql;
   logic       cont_eql;
   logic [3:0] count;
   logic [1:0] code_out;
   logic       code_valid;
   logic       active;

   int compared   = 0;
   int mismatched = 0;

   b06_cmp_cnt #(.DW(8), .CW(4), .TERM(10)) dut (
      .clock        (clock),
      .reset        (reset),
      .cc_mux       (cc_mux),
      .uscite       (uscite),
      .enable_count (enable_count),
      .ackout       (ackout),
      .data_in      (data_in),
      .ref_in       (ref_in),
      .ref_load     (ref_load),
      .eql          (eql),
      .cont_eql     (cont_eql),
      .count        (count),
      .code_out     (code_out),
      .code_valid   (code_valid),
      .active       (active)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one edge and settle before sampling.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic e_eql, input logic e_cont,
                            input logic [3:0] e_cnt, input logic [1:0] e_code,
                            input logic e_valid, input logic e_active);
      check({tag, ".eql"},        32'(eql),        32'(e_eql));
      check({tag, ".cont_eql"},   32'(cont_eql),   32'(e_cont));
      check({tag, ".count"},      32'(count),      32'(e_cnt));
      check({tag, ".code_out"},   32'(code_out),   32'(e_code));
      check({tag, ".code_valid"}, 32'(code_valid), 32'(e_valid));
      check({tag, ".active"},     32'(active),     32'(e_active));
   endtask

   initial begin
      // Reset with random inputs for two cycles.
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cc_mux       = 2'($urandom);
         uscite       = 2'($urandom);
         enable_count = 1'($urandom);
         ackout       = 1'($urandom);
         data_in      = 8'($urandom);
         ref_in       = 8'($urandom);
         ref_load     = 1'($urandom);
         step();
      end
      check_all("reset", 0, 0, 4'd0, 2'b00, 0, 0);

      cc_mux = 2'b00; uscite = 2'b00; enable_count = 0; ackout = 0;
      data_in = 8'h00; ref_in = 8'h00; ref_load = 0;
      reset = 1'b1;
      step();
      check("idle.active", 32'(active), 32'd0);

      // Load reference and enter CMP.
      ref_load = 1; ref_in = 8'hA5;
      step();
      check("load.active", 32'(active), 32'd1);
      check("load.eql",    32'(eql),    32'd0);
      ref_load = 0;

      cc_mux = 2'b01; data_in = 8'hA5; step();
      check("cmp01_match", 32'(eql), 32'd1);
      cc_mux = 2'b01; data_in = 8'h00; step();
      check("cmp01_miss",  32'(eql), 32'd0);
      cc_mux = 2'b10; data_in = 8'h5A; step();
      check("cmp10_match", 32'(eql), 32'd1);
      cc_mux = 2'b00; data_in = 8'h00; step();
      check("cmp00_hold",  32'(eql), 32'd1);
      // sample_reg now 00; live data_in would match but sampled one must not.
      cc_mux = 2'b11; data_in = 8'hA5; step();
      check("cmp11_sample_miss",  32'(eql), 32'd0);
      cc_mux = 2'b11; data_in = 8'h00; step();
      check("cmp11_sample_match", 32'(eql), 32'd1);

      // Reload in CMP: this cycle still compares against A5.
      ref_load = 1; ref_in = 8'h3C; cc_mux = 2'b01; data_in = 8'hA5; step();
      check("reload_old_ref", 32'(eql),    32'd1);
      check("reload_active",  32'(active), 32'd1);
      check("reload_count",   32'(count),  32'd0);
      ref_load = 0; data_in = 8'h3C; step();
      check("reload_new_ref", 32'(eql), 32'd1);
      cc_mux = 2'b00;

      // Count run: ten enabled cycles from 0.
      enable_count = 1;
      for (int k = 1; k <= 10; k++) begin
         step();
`ifdef B06_CNT_SAT_EN
         check("run.count", 32'(count),    32'((k >= 9) ? 9 : k));
         check("run.cont",  32'(cont_eql), 32'((k >= 9) ? 1 : 0));
`else
         check("run.count", 32'(count),    32'((k == 10) ? 0 : k));
         check("run.cont",  32'(cont_eql), 32'((k == 10) ? 1 : 0));
`endif
      end
      enable_count = 0; step();
      check("run_stop.count", 32'(count),    32'd0);
      check("run_stop.cont",  32'(cont_eql), 32'd0);

      // Pause: enable 1,1,0,1 gives 1,2,2,3.
      enable_count = 1; step(); check("pause1", 32'(count), 32'd1);
      enable_count = 1; step(); check("pause2", 32'(count), 32'd2);
      enable_count = 0; step(); check("pause3", 32'(count), 32'd2);
      enable_count = 1; step(); check("pause4", 32'(count), 32'd3);
      enable_count = 0;

      // Ack capture: held-high ackout strobes once.
      uscite = 2'b11; ackout = 1;
      step(); check_all("ack1", 1, 0, 4'd3, 2'b11, 1, 1);
      step(); check_all("ack2", 1, 0, 4'd3, 2'b11, 0, 1);
      step(); check_all("ack3", 1, 0, 4'd3, 2'b11, 0, 1);
      ackout = 0; step();
      check("ack_low.valid", 32'(code_valid), 32'd0);
      uscite = 2'b01; ackout = 1; step();
      check("ack_edge2.code",  32'(code_out),   32'd1);
      check("ack_edge2.valid", 32'(code_valid), 32'd1);
      ackout = 0;

      // Count to 6 in CNT, then reset with a simultaneous ackout edge.
      enable_count = 1;
      step(); step(); step();
      check("pre_reset.count", 32'(count), 32'd6);
      reset = 0; ackout = 1; uscite = 2'b10; step();
      check_all("mid_reset", 0, 0, 4'd0, 2'b00, 0, 0);

      // Leave reset with ackout high in IDLE; edge is consumed there.
      reset = 1; step();
      check("idle_ack.valid", 32'(code_valid), 32'd0);
      check("idle_ack.count", 32'(count),      32'd0);
      // Load with enable_count in IDLE: move to CMP, no count.
      ref_load = 1; ref_in = 8'h11; step();
      check("idle_load_en.count",  32'(count),      32'd0);
      check("idle_load_en.active", 32'(active),     32'd1);
      check("idle_load_en.valid",  32'(code_valid), 32'd0);
      ref_load = 0; enable_count = 0; step();
      check("post_idle_ack.valid", 32'(code_valid), 32'd0);
      check("post_idle_ack.code",  32'(code_out),   32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/b06_cmp_cnt.md
Name: b06_cmp_cnt

Overview:
- Datapath and counter peer of the b06 interrupt-handler FSM.
- Consumes cc_mux, uscite, enable_count and ackout from the handler.
- Produces the eql (operand match) and cont_eql (count terminal) inputs that the handler branches on.
- Captures each uscite code on the ackout rising edge and presents it downstream.

Parameters:
- DW, 8, operand/reference width.
- CW, 4, counter width.
- TERM, 10, counter modulus; legal range 2..2**CW.

Ports:
- clock  in  1  single clock, all state updates on posedge.
- reset  in  1  synchronous, active-low; reset==0 at posedge clears all state.
- cc_mux  in  2  operand-source select from the handler.
- uscite  in  2  handler output code.
- enable_count  in  1  counter enable from the handler.
- ackout  in  1  handler acknowledge.
- data_in  in  DW  live operand.
- ref_in  in  DW  reference value.
- ref_load  in  1  load ref_in into ref_reg.
- eql  out  1  registered compare result.
- cont_eql  out  1  registered counter-terminal flag.
- count  out  CW  current counter value.
- code_out  out  2  last captured uscite.
- code_valid  out  1  one-cycle strobe for code_out.
- active  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset==0 at posedge) forces:
  - state=IDLE; eql=0, cont_eql=0, count=0, code_out=00, code_valid=0, active=0;
  - ref_reg=0, sample_reg=0, ack_d=0.
  - Reset overrides every other input. Reset mid-count discards count; no code_valid is issued.
- Registers: every output is registered; latency is 1 cycle from input to output.
- Operand select (sel), decoded from cc_mux:
  - 00: eql holds its previous value.
  - 01: sel=data_in.
  - 10: sel=~data_in.
  - 11: sel=sample_reg, which is data_in registered every non-reset cycle.
- FSM states: IDLE, CMP, CNT.
- IDLE:
  - eql=0, cont_eql=0, count held.
  - ref_load=1 loads ref_reg<=ref_in and moves to CMP.
- CMP:
  - eql<=(sel==ref_reg), full DW-bit compare, unless cc_mux==00.
  - enable_count=1 moves to CNT in the same cycle and also increments count.
- CNT:
  - eql is updated as in CMP.
  - With enable_count=1: if count==TERM-1, count<=0 and cont_eql<=1 for exactly one cycle; else count<=count+1 and cont_eql<=0.
  - enable_count=0 returns to CMP with count held and cont_eql<=0.
- ref_load in CMP or CNT reloads ref_reg with no state change. The compare in that same cycle uses the old ref_reg.
- Ack capture (any state except IDLE):
  - ack_d<=ackout every cycle.
  - Rising edge (ackout==1 && ack_d==0) gives code_out<=uscite and code_valid<=1 for one cycle.
  - ackout held high gives no repeat strobe.
  - In IDLE, ack_d still tracks ackout, so an edge that arrives in IDLE never strobes later.
- Simultaneous events:
  - Rising ackout and count wrap in the same cycle: both take effect independently.
  - ref_load with enable_count in IDLE: load and move to CMP only; no count.
- Arithmetic: count is unsigned CW bits. No value >= TERM is ever reachable after reset.

Optional Feature:
- Macro: B06_CNT_SAT_EN.
- Defined: count saturates at TERM-1 instead of wrapping.
  - cont_eql stays high while count==TERM-1 and the state is CNT.
  - cont_eql clears, and count returns to 0, on the cycle enable_count drops.
- Undefined: wrap-to-0 behaviour with a one-cycle cont_eql pulse, as above.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs -> all outputs 0, state IDLE, active=0.
- Compare:
  - Setup: ref_load=1 with ref_in=8'hA5, then cc_mux=01 with data_in=8'hA5 -> eql=1 next cycle.
  - data_in=8'h5A with cc_mux=10 -> eql=1.
  - data_in=8'h00 with cc_mux=01 -> eql=0.
  - cc_mux=00 -> eql held.
- Count wrap: TERM=10, state CMP, enable_count=1 for 10 cycles -> count 1..9 then 0; cont_eql=1 only on the cycle count returns to 0. With B06_CNT_SAT_EN: count stays 9, cont_eql stays 1 until enable_count=0.
- Ack capture: active, uscite=11, ackout 0->1 held 3 cycles -> code_out=11, code_valid=1 for exactly one cycle. Second edge with uscite=01 -> code_out=01.
- Reset mid-op: reset=0 while count=6 in CNT -> count=0, state IDLE; no code_valid even if ackout rises the same cycle.
- Pause: enable_count 1,1,0,1 from count=0 -> count 1,2,2,3; state goes CNT, CNT, CMP, CNT.
